mem_apb_sequencer: RTL and testbench
====================================

Name: mem_apb_sequencer

Overview:
- Upstream master for the ALU APB slave, and the sole client of the word-addressed memory model.
- Fetches operation records (operand A, operand B, opcode) from memory and issues them to the ALU as APB writes.
- Reads back the ALU result over APB and writes it to a result region in memory.
- After the last job, pulses the memory dump request so the result image is written to file.

Parameters:
- ADDR_WIDTH, 16, memory address width; all memory addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 14, memory word and APB data width.
- APB_ADDR_WIDTH, 8, APB address width.
- JOB_CNT_WIDTH, 8, width of the job counter.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_base_addr  in  ADDR_WIDTH  first record address; captured at start.
- i_res_base  in  ADDR_WIDTH  first result address; captured at start.
- i_job_count  in  JOB_CNT_WIDTH  number of records; captured at start.
- o_busy  out  1  high from the cycle after start is accepted until DONE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky PSLVERR flag; cleared on the next accepted start.
- o_mem_en, o_mem_wr  out  1 each  memory enable and write strobe.
- o_mem_addr  out  ADDR_WIDTH  memory read address.
- o_mem_write_addr  out  ADDR_WIDTH  memory write address.
- o_mem_data_w  out  DATA_WIDTH  memory write data.
- i_mem_data_r  in  DATA_WIDTH  memory read data; registered, valid one cycle after the read request.
- o_mem_dump  out  1  memory dump request.
- o_psel, o_penable, o_pwrite  out  1 each  APB control.
- o_paddr  out  APB_ADDR_WIDTH  APB address.
- o_pwdata  out  DATA_WIDTH  APB write data.
- i_pready, i_pslverr  in  1 each  APB response.
- i_prdata  in  DATA_WIDTH  APB read data.

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE and all outputs go to 0 immediately, including o_psel and o_penable mid-transfer.
  - Job index j = 0 and word index k = 0.
- Record layout: record j occupies base+3j+k, with k=0 operand A, k=1 operand B, k=2 opcode.
- ALU APB map: A = 0x00, B = 0x04, OP = 0x08 (the write starts the operation), RES = 0x0C (read).
- IDLE:
  - i_start=1 captures the inputs, clears o_err, and asserts o_busy.
  - If job_count=0, go directly to DONE, with no memory or APB activity and no dump.
  - Otherwise go to RD_REQ.
- RD_REQ: o_mem_en=1, o_mem_wr=0, o_mem_addr = base+3j+k; next state RD_WAIT.
- RD_WAIT: latch i_mem_data_r into the write-data register; next state APB_SETUP.
- APB_SETUP: o_psel=1, o_penable=0, o_pwrite=1, o_paddr = 4k, o_pwdata = latched word. For the result read use o_pwrite=0 and o_paddr = 0x0C. Next state APB_ACCESS.
- APB_ACCESS:
  - o_psel=1 and o_penable=1; all APB outputs stay stable until i_pready=1.
  - On i_pready=1 with i_pslverr=1: set o_err and go to DUMP. This aborts the remaining jobs; results already written are kept.
  - On i_pready=1 after a write with k<2: k++ and go to RD_REQ.
  - On i_pready=1 after the k=2 write: go to APB_SETUP for the result read.
  - On i_pready=1 after the read: latch i_prdata and go to WB.
- WB:
  - o_mem_en=1, o_mem_wr=1, o_mem_write_addr = res_base+j, o_mem_data_w = result.
  - Then k=0 and j++.
  - If j == job_count, go to DUMP; otherwise go to RD_REQ.
- DUMP: o_mem_dump=1 for exactly one cycle, always after the final WB has been committed; next state DONE.
- DONE: o_done=1 and o_busy=0 for one cycle; next state IDLE.
- o_mem_en is 0 in every state except RD_REQ and WB. o_psel is 0 outside the APB states.
- Timing with zero APB wait states:
  - 15 cycles per job.
  - o_busy is high for 15N+1 cycles, then o_done pulses.
  - Each APB wait cycle adds one cycle.
- i_start is ignored while busy and in DONE; captured inputs are not re-sampled.
- Address arithmetic is modulo 2^ADDR_WIDTH; for example base = 0xFFFE reads 0xFFFE, 0xFFFF, 0x0000.

Test Plan:
1. Reset mid APB_ACCESS (o_psel=1) -> o_psel, o_penable, o_mem_en and o_busy are 0 within the same cycle; after release the FSM is in IDLE and o_done never pulses.
2. One job: memory[0x10..0x12] = 5, 3, 0 (ADD); ALU model returns 8; i_res_base = 0x80, zero wait -> APB writes 0x00=5, 0x04=3, 0x08=0, then read 0x0C; memory[0x80] = 8; o_busy high 16 cycles; o_dump for 1 cycle, then o_done.
3. Three jobs, 2 PREADY wait states on every transfer -> results at res_base+0..2; busy for 3×(15+8)+1 = 70 cycles; APB outputs stable during the waits.
4. PSLVERR on the opcode write of job 1 of 3 -> job 0 result written, no write at res_base+1 or +2; o_err=1 and stays 1 through IDLE; the next start clears it.
5. i_job_count = 0 -> o_done pulses the cycle after start; o_mem_en, o_psel and o_mem_dump stay 0.
6. base = 0xFFFE with 1 job -> reads at 0xFFFE, 0xFFFF, 0x0000; a start pulse while busy is ignored.

Source files
------------

// File: rtl/mem_apb_sequencer_if.sv
// Bundles the memory-model port and the APB master port of mem_apb_sequencer.
// The master modport is the sequencer side; the slave modport is the memory/ALU side.
interface mem_apb_sequencer_if #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 14,
    parameter int APB_ADDR_WIDTH = 8
);
    logic                      o_mem_en;
    logic                      o_mem_wr;
    logic [ADDR_WIDTH-1:0]     o_mem_addr;
    logic [ADDR_WIDTH-1:0]     o_mem_write_addr;
    logic [DATA_WIDTH-1:0]     o_mem_data_w;
    logic [DATA_WIDTH-1:0]     i_mem_data_r;
    logic                      o_mem_dump;

    // APB: a transfer completes on the first ACCESS cycle (psel & penable) in
    // which pready is high; paddr/pwrite/pwdata stay stable until then.
    logic                      o_psel;
    logic                      o_penable;
    logic                      o_pwrite;
    logic [APB_ADDR_WIDTH-1:0] o_paddr;
    logic [DATA_WIDTH-1:0]     o_pwdata;
    logic                      i_pready;
    logic                      i_pslverr;
    logic [DATA_WIDTH-1:0]     i_prdata;

    modport master (
        output o_mem_en, o_mem_wr, o_mem_addr, o_mem_write_addr, o_mem_data_w, o_mem_dump,
        output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
        input  i_mem_data_r, i_pready, i_pslverr, i_prdata
    );

    modport slave (
        input  o_mem_en, o_mem_wr, o_mem_addr, o_mem_write_addr, o_mem_data_w, o_mem_dump,
        input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
        output i_mem_data_r, i_pready, i_pslverr, i_prdata
    );
endinterface

// File: rtl/mem_apb_sequencer.sv
// Fetches (A, B, opcode) records from memory, runs them through the APB ALU and
// writes each result back to memory; requests a memory dump after the last job.
module mem_apb_sequencer #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 14,
    parameter int APB_ADDR_WIDTH = 8,
    parameter int JOB_CNT_WIDTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [ADDR_WIDTH-1:0]    i_base_addr,
    input  logic [ADDR_WIDTH-1:0]    i_res_base,
    input  logic [JOB_CNT_WIDTH-1:0] i_job_count,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [2:0]               o_dbg_state,
    mem_apb_sequencer_if.master      bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_REQ     = 3'd1,
        S_RD_WAIT    = 3'd2,
        S_APB_SETUP  = 3'd3,
        S_APB_ACCESS = 3'd4,
        S_WB         = 3'd5,
        S_DUMP       = 3'd6,
        S_DONE       = 3'd7
    } state_t;

    state_t                    r_state;
    logic [ADDR_WIDTH-1:0]     r_base;
    logic [ADDR_WIDTH-1:0]     r_res_base;
    logic [JOB_CNT_WIDTH-1:0]  r_count;
    logic [JOB_CNT_WIDTH-1:0]  r_j;
    logic [1:0]                r_k;
    logic                      r_is_read;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;
    logic                      r_mem_en;
    logic                      r_mem_wr;
    logic [ADDR_WIDTH-1:0]     r_mem_addr;
    logic [ADDR_WIDTH-1:0]     r_mem_write_addr;
    logic [DATA_WIDTH-1:0]     r_mem_data_w;
    logic                      r_mem_dump;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0]     r_pwdata;

    logic [JOB_CNT_WIDTH-1:0]  w_j_next;
    logic [1:0]                w_k_next;

    assign w_j_next = r_j + JOB_CNT_WIDTH'(1);
    assign w_k_next = r_k + 2'd1;

    // Record word address base + 3j + k, wrapping modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] rec_addr(
        input logic [ADDR_WIDTH-1:0]    base,
        input logic [JOB_CNT_WIDTH-1:0] j,
        input logic [1:0]               k
    );
        logic [ADDR_WIDTH-1:0] jj;
        jj = ADDR_WIDTH'(j);
        return base + jj + jj + jj + ADDR_WIDTH'(k);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_base           <= '0;
            r_res_base       <= '0;
            r_count          <= '0;
            r_j              <= '0;
            r_k              <= '0;
            r_is_read        <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err            <= 1'b0;
            r_mem_en         <= 1'b0;
            r_mem_wr         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_write_addr <= '0;
            r_mem_data_w     <= '0;
            r_mem_dump       <= 1'b0;
            r_psel           <= 1'b0;
            r_penable        <= 1'b0;
            r_pwrite         <= 1'b0;
            r_paddr          <= '0;
            r_pwdata         <= '0;
        end else begin
            r_done     <= 1'b0;
            r_mem_dump <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_base     <= i_base_addr;
                        r_res_base <= i_res_base;
                        r_count    <= i_job_count;
                        r_err      <= 1'b0;
                        r_j        <= '0;
                        r_k        <= '0;
                        r_is_read  <= 1'b0;
                        if (i_job_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_RD_REQ;
                            r_busy     <= 1'b1;
                            r_mem_en   <= 1'b1;
                            r_mem_wr   <= 1'b0;
                            r_mem_addr <= i_base_addr;
                        end
                    end
                end
                S_RD_REQ: begin
                    r_state  <= S_RD_WAIT;
                    r_mem_en <= 1'b0;
                end
                S_RD_WAIT: begin
                    r_state   <= S_APB_SETUP;
                    r_psel    <= 1'b1;
                    r_penable <= 1'b0;
                    r_pwrite  <= 1'b1;
                    r_paddr   <= APB_ADDR_WIDTH'({r_k, 2'b00});
                    r_pwdata  <= bus.i_mem_data_r;
                end
                S_APB_SETUP: begin
                    r_state   <= S_APB_ACCESS;
                    r_penable <= 1'b1;
                end
                S_APB_ACCESS: begin
                    if (bus.i_pready) begin
                        r_penable <= 1'b0;
                        if (bus.i_pslverr) begin
                            // Abort the remaining jobs; already written results stay.
                            r_err      <= 1'b1;
                            r_psel     <= 1'b0;
                            r_pwrite   <= 1'b0;
                            r_state    <= S_DUMP;
                            r_mem_dump <= 1'b1;
                        end else if (r_is_read) begin
                            r_psel           <= 1'b0;
                            r_pwrite         <= 1'b0;
                            r_state          <= S_WB;
                            r_mem_en         <= 1'b1;
                            r_mem_wr         <= 1'b1;
                            r_mem_write_addr <= r_res_base + ADDR_WIDTH'(r_j);
                            r_mem_data_w     <= bus.i_prdata;
                        end else if (r_k == 2'd2) begin
                            // Opcode written: the ALU is running, fetch its result.
                            r_state   <= S_APB_SETUP;
                            r_is_read <= 1'b1;
                            r_pwrite  <= 1'b0;
                            r_paddr   <= APB_ADDR_WIDTH'(8'h0C);
                        end else begin
                            r_psel     <= 1'b0;
                            r_k        <= w_k_next;
                            r_state    <= S_RD_REQ;
                            r_mem_en   <= 1'b1;
                            r_mem_wr   <= 1'b0;
                            r_mem_addr <= rec_addr(r_base, r_j, w_k_next);
                        end
                    end
                end
                S_WB: begin
                    r_mem_en  <= 1'b0;
                    r_mem_wr  <= 1'b0;
                    r_k       <= '0;
                    r_j       <= w_j_next;
                    r_is_read <= 1'b0;
                    if (w_j_next == r_count) begin
                        r_state    <= S_DUMP;
                        r_mem_dump <= 1'b1;
                    end else begin
                        r_state    <= S_RD_REQ;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= rec_addr(r_base, w_j_next, 2'd0);
                    end
                end
                S_DUMP: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy               = r_busy;
    assign o_done               = r_done;
    assign o_err                = r_err;
    assign o_dbg_state          = r_state;
    assign bus.o_mem_en         = r_mem_en;
    assign bus.o_mem_wr         = r_mem_wr;
    assign bus.o_mem_addr       = r_mem_addr;
    assign bus.o_mem_write_addr = r_mem_write_addr;
    assign bus.o_mem_data_w     = r_mem_data_w;
    assign bus.o_mem_dump       = r_mem_dump;
    assign bus.o_psel           = r_psel;
    assign bus.o_penable        = r_penable;
    assign bus.o_pwrite         = r_pwrite;
    assign bus.o_paddr          = r_paddr;
    assign bus.o_pwdata         = r_pwdata;

endmodule

// File: tb/tb_mem_apb_sequencer.sv
// Bench for mem_apb_sequencer: word memory and APB ALU models on the slave side,
// a job-level reference model producing expected reads, APB transfers, writes and timing.
module tb_mem_apb_sequencer;

    localparam int AW  = 16;
    localparam int DW  = 14;
    localparam int AAW = 8;
    localparam int JW  = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] res_base;
    logic [JW-1:0] job_count;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    dbg_state;

    mem_apb_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APB_ADDR_WIDTH(AAW)) bus ();

    mem_apb_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APB_ADDR_WIDTH(AAW), .JOB_CNT_WIDTH(JW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
        .i_res_base(res_base), .i_job_count(job_count), .o_busy(busy), .o_done(done),
        .o_err(err), .o_dbg_state(dbg_state), .bus(bus.master)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [DW-1:0] op);
        case (op[2:0])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // ---------------- memory + ALU slave models / monitor ----------------
    logic [DW-1:0]      mem [0:65535];
    logic [AW-1:0]      obs_rd_q[$];
    logic [AW+DW-1:0]   obs_wr_q[$];
    logic [AAW+DW:0]    obs_apb_q[$];
    int                 n_wait;
    int                 err_at;
    int                 xfer_idx;
    int                 wcnt;
    int                 cyc_n;
    int                 dump_cnt;
    int                 dump_cyc;
    int                 dump_wr_n;
    int                 done_cyc;
    logic [DW-1:0]      alu_a, alu_b, alu_op;
    logic [AAW+DW:0]    apb_cur, apb_snap;

    always @(negedge clk) begin
        cyc_n++;
        if (!rst_n) begin
            bus.i_pready     = 1'b0;
            bus.i_pslverr    = 1'b0;
            bus.i_prdata     = '0;
            bus.i_mem_data_r = '0;
            wcnt             = 0;
        end else begin
            if (bus.o_mem_en && !bus.o_mem_wr) begin
                bus.i_mem_data_r = mem[bus.o_mem_addr];
                obs_rd_q.push_back(bus.o_mem_addr);
            end
            if (bus.o_mem_en && bus.o_mem_wr) begin
                mem[bus.o_mem_write_addr] = bus.o_mem_data_w;
                obs_wr_q.push_back({bus.o_mem_write_addr, bus.o_mem_data_w});
            end
            if (bus.o_mem_dump) begin
                dump_cnt++;
                dump_cyc  = cyc_n;
                dump_wr_n = obs_wr_q.size();
            end
            if (done) done_cyc = cyc_n;
            bus.i_pready  = 1'b0;
            bus.i_pslverr = 1'b0;
            if (bus.o_psel && bus.o_penable) begin
                apb_cur = {bus.o_pwrite, bus.o_paddr, bus.o_pwrite ? bus.o_pwdata : {DW{1'b0}}};
                if (wcnt == 0) apb_snap = apb_cur;
                else check("apb_stable", 32'(apb_cur), 32'(apb_snap));
                if (wcnt == n_wait) begin
                    bus.i_pready  = 1'b1;
                    bus.i_pslverr = (xfer_idx == err_at);
                    obs_apb_q.push_back(apb_cur);
                    xfer_idx++;
                    if (bus.o_pwrite) begin
                        case (bus.o_paddr)
                            8'h00:   alu_a  = bus.o_pwdata;
                            8'h04:   alu_b  = bus.o_pwdata;
                            8'h08:   alu_op = bus.o_pwdata;
                            default: ;
                        endcase
                    end else begin
                        bus.i_prdata = alu(alu_a, alu_b, alu_op);
                    end
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] rb, input int n,
                       input int w, input int err_rel, input int poke_at);
        logic [AW-1:0]    exp_rd_q[$];
        logic [AW+DW-1:0] exp_wr_q[$];
        logic [AAW+DW:0]  exp_apb_q[$];
        logic [DW-1:0]    ops [3];
        logic [AW-1:0]    a16;
        int idx, exp_cyc, busy_cyc, g, rd0, wr0, apb0, dump0;
        bit aborted;

        // Job-level model: walk the records, count cycles per step.
        idx = 0; exp_cyc = 0; aborted = 0;
        for (int j = 0; j < n && !aborted; j++) begin
            for (int k = 0; k < 3 && !aborted; k++) begin
                a16 = b + AW'(3 * j + k);
                exp_rd_q.push_back(a16);
                ops[k] = mem[a16];
                exp_apb_q.push_back({1'b1, AAW'(4 * k), ops[k]});
                exp_cyc += 4 + w;
                if (idx == err_rel) aborted = 1;
                idx++;
            end
            if (!aborted) begin
                exp_apb_q.push_back({1'b0, 8'h0C, {DW{1'b0}}});
                exp_cyc += 2 + w;
                if (idx == err_rel) aborted = 1;
                idx++;
                if (!aborted) begin
                    exp_wr_q.push_back({rb + AW'(j), alu(ops[0], ops[1], ops[2])});
                    exp_cyc += 1;
                end
            end
        end
        if (n > 0) exp_cyc += 1;

        rd0 = obs_rd_q.size(); wr0 = obs_wr_q.size(); apb0 = obs_apb_q.size(); dump0 = dump_cnt;
        err_at = (err_rel < 0) ? -1 : xfer_idx + err_rel;
        n_wait = w;

        base_addr = b; res_base = rb; job_count = JW'(n); start = 1'b1;
        tick();
        start = 1'b0;
        check("err_clr_on_start", 32'(err), 0);
        busy_cyc = 0; g = 0;
        while (!done && g < 4000) begin
            if (busy) busy_cyc++;
            start = (g == poke_at);
            if (g == poke_at) begin
                base_addr = 16'($urandom); res_base = 16'($urandom); job_count = 8'($urandom);
            end
            g++;
            tick();
        end
        start = 1'b0;
        check("done_timeout", 32'(g < 4000), 1);
        check("busy_cycles", busy_cyc, exp_cyc);
        check("busy_at_done", 32'(busy), 0);
        tick();
        check("done_width", 32'(done), 0);
        check("idle_after", 32'(dbg_state), 0);
        check("err_flag", 32'(err), 32'(aborted));

        check("rd_count", obs_rd_q.size() - rd0, exp_rd_q.size());
        for (int i = 0; i < exp_rd_q.size() && rd0 + i < obs_rd_q.size(); i++)
            check("rd_addr", 32'(obs_rd_q[rd0 + i]), 32'(exp_rd_q[i]));
        check("apb_count", obs_apb_q.size() - apb0, exp_apb_q.size());
        for (int i = 0; i < exp_apb_q.size() && apb0 + i < obs_apb_q.size(); i++)
            check("apb_xfer", 32'(obs_apb_q[apb0 + i]), 32'(exp_apb_q[i]));
        check("wr_count", obs_wr_q.size() - wr0, exp_wr_q.size());
        for (int i = 0; i < exp_wr_q.size() && wr0 + i < obs_wr_q.size(); i++)
            check("wr_data", 32'(obs_wr_q[wr0 + i]), 32'(exp_wr_q[i]));
        check("dump_count", dump_cnt - dump0, (n > 0) ? 1 : 0);
        if (n > 0) begin
            check("dump_after_wb", dump_wr_n - wr0, exp_wr_q.size());
            check("dump_to_done", done_cyc - dump_cyc, 1);
        end
    endtask

    initial begin
        int dn, n, w, e;
        logic [AW-1:0] b;
        n_vec = 0; n_err = 0; n_wait = 0; err_at = -1; xfer_idx = 0; wcnt = 0;
        cyc_n = 0; dump_cnt = 0; dump_cyc = 0; dump_wr_n = 0; done_cyc = 0;
        alu_a = '0; alu_b = '0; alu_op = '0;
        for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
        rst_n = 1'b0; start = 1'b0; base_addr = '0; res_base = '0; job_count = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_psel", 32'(bus.o_psel), 0);
        check("rst_mem_en", 32'(bus.o_mem_en), 0);
        check("rst_state", 32'(dbg_state), 0);
        rst_n = 1'b1;
        tick();

        // Reset while an APB access is being held by wait states.
        n_wait = 6; err_at = -1;
        base_addr = 16'h0200; res_base = 16'h0300; job_count = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && !(bus.o_psel && bus.o_penable); i++) tick();
        check("t1_in_access", 32'(bus.o_psel && bus.o_penable), 1);
        rst_n = 1'b0;
        #1;
        check("t1_psel", 32'(bus.o_psel), 0);
        check("t1_penable", 32'(bus.o_penable), 0);
        check("t1_mem_en", 32'(bus.o_mem_en), 0);
        check("t1_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t1_idle", 32'(dbg_state), 0);
        dn = 0;
        repeat (30) begin
            if (done) dn++;
            tick();
        end
        check("t1_no_done", dn, 0);

        // One ADD job, zero wait states.
        mem[16'h0010] = 14'd5; mem[16'h0011] = 14'd3; mem[16'h0012] = 14'd0;
        run(16'h0010, 16'h0080, 1, 0, -1, -1);
        check("t2_result", 32'(mem[16'h0080]), 8);

        // Three jobs, two wait states on every transfer.
        run(16'h0400, 16'h0500, 3, 2, -1, -1);

        // PSLVERR on the opcode write of job 1.
        run(16'h0600, 16'h0700, 3, 0, 6, -1);
        repeat (3) tick();
        check("t4_err_sticky", 32'(err), 1);

        // Zero jobs.
        run(16'h0800, 16'h0900, 0, 0, -1, -1);

        // Wrapping record addresses plus an ignored start while busy.
        run(16'hFFFE, 16'h1000, 1, 1, -1, 4);

        // Randomized jobs.
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 4);
            w = $urandom_range(0, 3);
            b = 16'($urandom);
            e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * n - 1) : -1;
            run(b, b + 16'h0100, n, w, e, $urandom_range(0, 1) ? $urandom_range(1, 20) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
